// File: rtl/memory2.sv
// Simple dual-port buffer RAM: one write and one registered read per cycle,
// selectable read-during-write behaviour, zero-fill engine and range flagging.
module memory2 #(
  parameter int W        = 8,
  parameter int L        = 10,
  parameter int AW       = 4,
  parameter int RDW_MODE = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_add,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_add,
  output logic [W-1:0]  rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic          err
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  localparam logic [AW:0]   DEPTH = (AW+1)'(L);
  localparam logic [AW-1:0] LAST  = AW'(L - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          err_q, err_d;

  logic [W-1:0]  mem_q [L];
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [W-1:0]  mem_wd;

  logic          accept;
  logic          wr_in_range, rd_in_range;
  logic          wr_ok, rd_ok, wr_bad, rd_bad, same_addr;

  // Accesses are only honoured in IDLE, and a clear request pre-empts them.
  assign accept      = (state_q == ST_IDLE) && !clear;
  assign wr_in_range = ({1'b0, wr_add} < DEPTH);
  assign rd_in_range = ({1'b0, rd_add} < DEPTH);
  assign wr_ok       = accept && wr_en && wr_in_range;
  assign rd_ok       = accept && rd_en && rd_in_range;
  assign wr_bad      = accept && wr_en && !wr_in_range;
  assign rd_bad      = accept && rd_en && !rd_in_range;
  assign same_addr   = (wr_add == rd_add);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    mem_we     = 1'b0;
    mem_wa     = wr_add;
    mem_wd     = wr_data;

    case (state_q)
      ST_CLEAR: begin
        mem_we = 1'b1;
        mem_wa = cnt_q;
        mem_wd = '0;
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      ST_IDLE: begin
        if (clear) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else begin
          mem_we = wr_ok;
          if (rd_ok) begin
            rd_valid_d = 1'b1;
            // Write-first forwards the incoming word; read-first sees the old array value.
            if ((RDW_MODE != 0) && wr_ok && same_addr) begin
              rd_data_d = wr_data;
            end else begin
              rd_data_d = mem_q[rd_add];
            end
          end
          err_d = wr_bad || rd_bad;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  // Array has no reset; the clear engine is responsible for zeroing it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign err      = err_q;
  assign busy     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_memory2.sv
// Directed bench for memory2: one instance per read-during-write mode,
// driven by shared stimulus and checked against hand-computed values.
module tb_memory2;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       wr_en;
  logic [3:0] wr_add;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [3:0] rd_add;
  logic [7:0] rd_data0, rd_data1;
  logic       rd_valid0, rd_valid1;
  logic       busy0, busy1;
  logic       err0, err1;

  int n_total = 0;
  int n_bad   = 0;

  memory2 #(.W(8), .L(10), .AW(4), .RDW_MODE(0)) u_rf (
    .clk(clk), .reset(reset), .clear(clear),
    .wr_en(wr_en), .wr_add(wr_add), .wr_data(wr_data),
    .rd_en(rd_en), .rd_add(rd_add),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .busy(busy0), .err(err0)
  );

  memory2 #(.W(8), .L(10), .AW(4), .RDW_MODE(1)) u_wf (
    .clk(clk), .reset(reset), .clear(clear),
    .wr_en(wr_en), .wr_add(wr_add), .wr_data(wr_data),
    .rd_en(rd_en), .rd_add(rd_add),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .busy(busy1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until both instances drop busy, bounded so a stuck engine still ends.
  task automatic count_busy(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while ((busy0 || busy1) && n < 30);
  endtask

  task automatic do_read(input string tag, input logic [3:0] a,
                         input logic [7:0] e0, input logic [7:0] e1);
    rd_en  = 1'b1;
    rd_add = a;
    step();
    check_val({tag, "_vld0"}, rd_valid0, 1);
    check_val({tag, "_vld1"}, rd_valid1, 1);
    check_val({tag, "_dat0"}, rd_data0, e0);
    check_val({tag, "_dat1"}, rd_data1, e1);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_add  = a;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    int n;
    reset   = 1'b0;
    clear   = 1'b0;
    wr_en   = 1'b0;
    wr_add  = '0;
    wr_data = '0;
    rd_en   = 1'b0;
    rd_add  = '0;

    // Reset state
    step();
    step();
    check_val("rst_busy", {busy1, busy0}, 2'b11);
    check_val("rst_vld",  {rd_valid1, rd_valid0}, 2'b00);
    check_val("rst_err",  {err1, err0}, 2'b00);
    check_val("rst_dat0", rd_data0, 0);
    check_val("rst_dat1", rd_data1, 0);

    // Power-up clear lasts exactly L edges
    reset = 1'b1;
    count_busy(n);
    check_val("pwr_busy_len", n, 10);
    for (int a = 0; a < 10; a++) do_read("pwr_rd", 4'(a), 8'd0, 8'd0);
    rd_en = 1'b0;
    step();
    check_val("pwr_vld_drop", {rd_valid1, rd_valid0}, 2'b00);

    // Basic access, back-to-back reads
    do_write(4'd0, 8'd10);
    do_write(4'd3, 8'd33);
    do_write(4'd5, 8'd66);
    do_read("bas_rd0", 4'd0, 8'd10, 8'd10);
    do_read("bas_rd1", 4'd1, 8'd0,  8'd0);
    do_read("bas_rd3", 4'd3, 8'd33, 8'd33);
    do_read("bas_rd5", 4'd5, 8'd66, 8'd66);

    // Collision: read-first returns 66, write-first returns 77
    wr_en = 1'b1; wr_add = 4'd5; wr_data = 8'd77;
    do_read("col_same", 4'd5, 8'd66, 8'd77);
    wr_en = 1'b0;
    do_read("col_after", 4'd5, 8'd77, 8'd77);
    rd_en = 1'b0;

    // Out-of-range write
    wr_en = 1'b1; wr_add = 4'd12; wr_data = 8'd99;
    step();
    wr_en = 1'b0;
    check_val("oor_wr_err", {err1, err0}, 2'b11);
    check_val("oor_wr_vld", {rd_valid1, rd_valid0}, 2'b00);
    step();
    check_val("oor_wr_err_drop", {err1, err0}, 2'b00);

    // Out-of-range read holds rd_data
    rd_en = 1'b1; rd_add = 4'd15;
    step();
    rd_en = 1'b0;
    check_val("oor_rd_err", {err1, err0}, 2'b11);
    check_val("oor_rd_vld", {rd_valid1, rd_valid0}, 2'b00);
    check_val("oor_rd_hold0", rd_data0, 77);
    check_val("oor_rd_hold1", rd_data1, 77);
    step();
    check_val("oor_rd_err_drop", {err1, err0}, 2'b00);

    // Both ports out of range: one pulse
    wr_en = 1'b1; wr_add = 4'd10; wr_data = 8'd5;
    rd_en = 1'b1; rd_add = 4'd11;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    check_val("oor_both_err", {err1, err0}, 2'b11);
    step();
    check_val("oor_both_drop", {err1, err0}, 2'b00);
    for (int a = 0; a < 10; a++) begin
      logic [7:0] e;
      e = (a == 0) ? 8'd10 : (a == 3) ? 8'd33 : (a == 5) ? 8'd77 : 8'd0;
      do_read("oor_nochg", 4'(a), e, e);
    end
    rd_en = 1'b0;
    step();

    // Clear in IDLE drops the concurrent write and ignores accesses while busy
    clear = 1'b1;
    wr_en = 1'b1; wr_add = 4'd2; wr_data = 8'd7;
    step();
    clear = 1'b0;
    check_val("clr_busy_start", {busy1, busy0}, 2'b11);
    wr_add = 4'd4; wr_data = 8'd8;
    rd_en  = 1'b1; rd_add = 4'd3;
    count_busy(n);
    wr_en = 1'b0; rd_en = 1'b0;
    check_val("clr_busy_len", n, 10);
    check_val("clr_vld_busy", {rd_valid1, rd_valid0}, 2'b00);
    for (int a = 0; a < 10; a++) do_read("clr_rd", 4'(a), 8'd0, 8'd0);
    rd_en = 1'b0;

    // Reset during clear
    do_write(4'd1, 8'd55);
    do_read("rdc_pre", 4'd1, 8'd55, 8'd55);
    rd_en = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    step(); step(); step();
    reset = 1'b0;
    #1;
    check_val("rdc_busy", {busy1, busy0}, 2'b11);
    check_val("rdc_vld",  {rd_valid1, rd_valid0}, 2'b00);
    check_val("rdc_err",  {err1, err0}, 2'b00);
    check_val("rdc_dat0", rd_data0, 0);
    check_val("rdc_dat1", rd_data1, 0);
    step(); step();
    reset = 1'b1;
    count_busy(n);
    check_val("rdc_busy_len", n, 10);
    do_read("rdc_post", 4'd1, 8'd0, 8'd0);
    rd_en = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
